cipher_group_formatter: RTL
===========================

# cipher_group_formatter

Output-side formatter placed directly downstream of the Enigma state machine. It consumes each enciphered ASCII letter and buffers it in a small FIFO. It re-emits the stream in the traditional five-letter cipher-group layout: a space between groups and CR LF after every line of groups. Output goes over a valid/ready byte handshake toward the UART transmitter. A flush request pads the final partial group with 'X' and terminates the line.

## Interface
- GROUP_LEN, 5: letters per group (2..15)
- LINE_GROUPS, 5: groups per line before CR LF (1..15)
- DEPTH, 16: FIFO entries, power of two
- PAD_CHAR, 8'h58: pad letter used by flush ('X')
- i_clock  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- i_data  in  8  enciphered ASCII letter from the state machine
- i_valid  in  1  one-cycle strobe, one letter per high cycle
- i_flush  in  1  one-cycle request to close the current group/line
- o_tx_data  out  8  byte to UART TX
- o_tx_valid  out  1  o_tx_data valid
- i_tx_ready  in  1  UART TX accepts byte this cycle
- o_full  out  1  FIFO count == DEPTH
- o_overflow  out  1  sticky: a letter was dropped

## Operation
- FIFO write: when i_valid=1 and not full. When full, the letter is dropped and o_overflow is set; o_overflow stays set until reset. Full is evaluated from the registered count, so a pop in the same cycle does not rescue the write.
- Counters:
  - chr_cnt counts letters emitted in the current group (0..GROUP_LEN-1).
  - grp_cnt counts completed groups in the current line (0..LINE_GROUPS-1).
  - sep_pend holds the pending separator: NONE, SPACE, or CRLF.
- Separators are lazy. When a group completes, sep_pend is set to SPACE, or to CRLF if grp_cnt wraps. The separator is emitted only immediately before the next letter or as part of a flush, so there is never a trailing space.
- FSM states: IDLE, CHAR, SPACE, CR, LF, PAD.
  - IDLE, FIFO not empty, sep_pend=SPACE: go to SPACE.
  - IDLE, FIFO not empty, sep_pend=CRLF: go to CR.
  - IDLE, FIFO not empty, sep_pend=NONE: load the head letter, pop it, go to CHAR.
  - IDLE, FIFO empty, flush_req set: go to PAD if chr_cnt≠0; go to CR if chr_cnt=0 and the line is non-empty; otherwise clear flush_req and stay in IDLE.
  - SPACE / CR: after the byte is accepted, clear sep_pend (CR goes on to LF) and return to IDLE.
  - LF: after acceptance, clear sep_pend and go to IDLE. If the LF is part of a flush, also clear flush_req, chr_cnt and grp_cnt.
  - PAD: emit PAD_CHAR until the group completes, then go to CR. The flush sequence emits CRLF even if grp_cnt would not wrap.
- i_flush is latched into flush_req. It is serviced only once the FIFO is empty, so letters already buffered are emitted first. Letters arriving during a flush are buffered and emitted after the flush completes.
- A line counts as non-empty when chr_cnt≠0, grp_cnt≠0, or sep_pend≠NONE.
- Bytes emitted are exactly 8'h20 (space), 8'h0D (CR), 8'h0A (LF), PAD_CHAR, or FIFO data. FIFO data is not checked.

## Timing
- Reset values: o_tx_data=0, o_tx_valid=0, o_full=0, o_overflow=0. FIFO, counters, sep_pend and flush_req are cleared; the FSM is in IDLE.
- Reset mid-transfer aborts the byte in flight and discards FIFO contents.
- Handshake:
  - A transfer occurs on a rising edge where o_tx_valid=1 and i_tx_ready=1.
  - o_tx_data must stay stable while o_tx_valid=1 and i_tx_ready=0.
  - o_tx_valid does not depend combinationally on i_tx_ready.
- Latency:
  - A letter sampled at edge N (FIFO previously empty, no separator pending) appears with o_tx_valid=1 after edge N+1.
  - The next byte can be presented on the edge after acceptance, giving one byte per 2 cycles at full rate.
- Counter arithmetic is modulo GROUP_LEN and LINE_GROUPS. Counters are 4 bits wide. The FIFO count is $clog2(DEPTH)+1 bits wide.
- i_valid and i_flush in the same cycle: the letter is written first, and the flush is serviced after it.

## Structure
- Shared package enigma_fmt_pkg holds:
  - ASCII constants SPACE, CR, LF.
  - The FSM state encoding.
  - The separator encoding NONE/SPACE/CRLF.
- Sub-module sync_fifo (parameters WIDTH, DEPTH) provides push, pop, head data, full, empty and count. It should be reusable on the input side.
- The formatter FSM and counters live in the top module.

## Test plan
- Reset: hold reset for 3 cycles -> all outputs 0. Release with no input -> o_tx_valid stays 0.
- Ready held at 1, push "HELLO" -> bytes H,E,L,L,O with no trailing space. Then push 'W' -> 8'h20 followed by W.
- Push 26 letters with defaults -> 25 letters in 5 groups separated by 4 spaces, then 0D, 0A, then the 26th letter.
- Backpressure: i_tx_ready=0 for 10 cycles during 'A' -> o_tx_data=8'h41 and o_tx_valid=1 stay stable. Exactly one 'A' is delivered when ready rises.
- Overflow: i_tx_ready=0, push 18 letters, DEPTH=16 -> the first letter sits in the output register, 16 are in the FIFO, and o_full=1. The 18th is dropped and o_overflow=1. Draining then yields exactly 17 letters.
- Flush: push "ABC", then i_flush -> A,B,C,X,X,0D,0A. Then push 'D' -> D with no leading separator. A flush with an empty line emits nothing.

Source files
------------

// File: rtl/enigma_fmt_pkg.sv
// Shared encodings for the cipher-group output formatter: ASCII control bytes,
// formatter FSM states and the pending-separator code.
package enigma_fmt_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHAR,
        ST_SPACE,
        ST_CR,
        ST_LF,
        ST_PAD
    } state_t;

    typedef enum logic [1:0] {
        SEP_NONE,
        SEP_SPACE,
        SEP_CRLF
    } sep_t;

    // Modulo counter step: wraps to zero after reaching 'last'.
    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] value,
                                                  input logic [CNT_W-1:0] last);
        return (value == last) ? '0 : value + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head_data shows the oldest entry
// so a consumer can load and pop it in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == FULL_CNT);
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cipher_group_formatter.sv
// Re-emits enciphered letters as five-letter cipher groups separated by spaces,
// with CR LF per line, over a registered valid/ready byte stream.
module cipher_group_formatter
    import enigma_fmt_pkg::*;
#(
    parameter int         GROUP_LEN   = 5,
    parameter int         LINE_GROUPS = 5,
    parameter int         DEPTH       = 16,
    parameter logic [7:0] PAD_CHAR    = 8'h58
) (
    input  logic       i_clock,
    input  logic       reset,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_flush,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_full,
    output logic       o_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]    FULL_CNT  = CW'(DEPTH);
    localparam logic [CNT_W-1:0] GRP_LAST  = CNT_W'(GROUP_LEN - 1);
    localparam logic [CNT_W-1:0] LINE_LAST = CNT_W'(LINE_GROUPS - 1);

    state_t           state_reg;
    sep_t             sep_pend_reg;
    logic [7:0]       tx_data_reg;
    logic             tx_valid_reg;
    logic [CNT_W-1:0] chr_cnt_reg;
    logic [CNT_W-1:0] grp_cnt_reg;
    logic             flush_req_reg;
    logic             flush_active_reg;
    logic             overflow_reg;

    logic [7:0]    fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          fifo_push;
    logic          fifo_pop;
    logic          accept;
    logic          line_busy;

    assign fifo_push  = i_valid && !fifo_full;
    assign fifo_pop   = (state_reg == ST_IDLE) && !fifo_empty && (sep_pend_reg == SEP_NONE);
    assign accept     = tx_valid_reg && i_tx_ready;
    assign line_busy  = (chr_cnt_reg != '0) || (grp_cnt_reg != '0) || (sep_pend_reg != SEP_NONE);

    assign o_tx_data  = tx_data_reg;
    assign o_tx_valid = tx_valid_reg;
    assign o_full     = (fifo_count == FULL_CNT);
    assign o_overflow = overflow_reg;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (i_clock),
        .srst      (reset),
        .push      (fifo_push),
        .push_data (i_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge i_clock) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            sep_pend_reg     <= SEP_NONE;
            tx_data_reg      <= '0;
            tx_valid_reg     <= 1'b0;
            chr_cnt_reg      <= '0;
            grp_cnt_reg      <= '0;
            flush_req_reg    <= 1'b0;
            flush_active_reg <= 1'b0;
            overflow_reg     <= 1'b0;
        end else begin
            if (i_valid && fifo_full) begin
                overflow_reg <= 1'b1;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        tx_valid_reg <= 1'b1;
                        case (sep_pend_reg)
                            SEP_SPACE: begin
                                tx_data_reg <= ASCII_SPACE;
                                state_reg   <= ST_SPACE;
                            end
                            SEP_CRLF: begin
                                tx_data_reg <= ASCII_CR;
                                state_reg   <= ST_CR;
                            end
                            default: begin
                                tx_data_reg <= fifo_head;
                                state_reg   <= ST_CHAR;
                            end
                        endcase
                    end else if (flush_req_reg) begin
                        // Flush only once every buffered letter has gone out.
                        if (chr_cnt_reg != '0) begin
                            tx_data_reg      <= PAD_CHAR;
                            tx_valid_reg     <= 1'b1;
                            flush_active_reg <= 1'b1;
                            state_reg        <= ST_PAD;
                        end else if (line_busy) begin
                            tx_data_reg      <= ASCII_CR;
                            tx_valid_reg     <= 1'b1;
                            flush_active_reg <= 1'b1;
                            state_reg        <= ST_CR;
                        end else begin
                            flush_req_reg <= 1'b0;
                        end
                    end
                end

                ST_CHAR: begin
                    if (accept) begin
                        tx_valid_reg <= 1'b0;
                        state_reg    <= ST_IDLE;
                        chr_cnt_reg  <= wrap_inc(chr_cnt_reg, GRP_LAST);
                        if (chr_cnt_reg == GRP_LAST) begin
                            grp_cnt_reg  <= wrap_inc(grp_cnt_reg, LINE_LAST);
                            sep_pend_reg <= (grp_cnt_reg == LINE_LAST) ? SEP_CRLF : SEP_SPACE;
                        end
                    end
                end

                ST_SPACE: begin
                    if (accept) begin
                        tx_valid_reg <= 1'b0;
                        sep_pend_reg <= SEP_NONE;
                        state_reg    <= ST_IDLE;
                    end
                end

                ST_CR: begin
                    if (accept) begin
                        tx_data_reg <= ASCII_LF;
                        state_reg   <= ST_LF;
                    end
                end

                ST_LF: begin
                    if (accept) begin
                        tx_valid_reg <= 1'b0;
                        sep_pend_reg <= SEP_NONE;
                        state_reg    <= ST_IDLE;
                        if (flush_active_reg) begin
                            flush_active_reg <= 1'b0;
                            flush_req_reg    <= 1'b0;
                            chr_cnt_reg      <= '0;
                            grp_cnt_reg      <= '0;
                        end
                    end
                end

                ST_PAD: begin
                    if (accept) begin
                        chr_cnt_reg <= wrap_inc(chr_cnt_reg, GRP_LAST);
                        if (chr_cnt_reg == GRP_LAST) begin
                            tx_data_reg <= ASCII_CR;
                            state_reg   <= ST_CR;
                        end
                    end
                end

                default: begin
                    tx_valid_reg <= 1'b0;
                    state_reg    <= ST_IDLE;
                end
            endcase

            // A new request arriving as the previous flush retires is kept.
            if (i_flush) begin
                flush_req_reg <= 1'b1;
            end
        end
    end

endmodule
